// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared widths, engine state encodings and the address range
// helper for the line memory responder.
package line_mem_pkg;

    localparam int unsigned LINE_W   = 128;
    localparam int unsigned ADDR_W   = 27;
    localparam int unsigned OFFSET_W = 4;
    // Wide enough for LATENCY up to 15
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    // True when any address bit above the line index field is set
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth_log2);
        logic v_oor;
        v_oor = 1'b0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (i >= OFFSET_W + depth_log2) begin
                v_oor = v_oor | addr[i];
            end
        end
        return v_oor;
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: simple dual-port line storage. One write port and one
// read-first synchronous read port; the read output register is the only
// state cleared by reset, the array itself is never cleared.
//   clk, rst          : clock, synchronous active-high reset (output reg only)
//   i_we/i_waddr/i_wdata : write enable, line index, line data
//   i_re/i_raddr      : read enable, line index
//   o_rdata           : registered read data, updates only when i_re is set
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [LINE_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [LINE_W-1:0]     o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: non-blocking sampling yields old contents on a same-edge write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency 128-bit line memory slave with
// independent write and read engines sharing one dual-port array.
//   clk, rst                    : clock, synchronous active-high reset
//   wr_addr/wr_data/wr_valid    : write request (byte address, line data)
//   wr_ready                    : high when idle; its return high marks completion
//   rd_addr/rd_avalid/rd_aready : read address handshake
//   rd_data/rd_valid/rd_dready  : read data handshake, data held until accepted
//   oor_err                     : sticky out-of-range address flag
// Optional feature: define LINE_MEM_OOR_CHECK_EN to enable oor_err; otherwise
// it is tied low and out-of-range addresses alias silently.
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_avalid,
    output logic              rd_aready,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_dready,
    output logic              oor_err
);

    // Write engine state
    w_state_e         r_w_state, w_w_state_nx;
    logic [CNT_W-1:0] r_w_cnt, w_w_cnt_nx;
    logic             r_wr_ready, w_wr_ready_nx;

    // Read engine state
    r_state_e          r_r_state, w_r_state_nx;
    logic [CNT_W-1:0]  r_r_cnt, w_r_cnt_nx;
    logic              r_rd_aready, w_rd_aready_nx;
    logic              r_rd_valid, w_rd_valid_nx;
    logic [LINE_W-1:0] r_rd_data, w_rd_data_nx;

    logic              w_wr_hs;
    logic              w_rd_hs;
    logic [LINE_W-1:0] w_arr_q;
    logic              w_unused_addr;

    // Handshakes are suppressed while reset is asserted
    assign w_wr_hs = wr_valid  & r_wr_ready  & ~rst;
    assign w_rd_hs = rd_avalid & r_rd_aready & ~rst;

    // Offset and (without range checking) upper bits are intentionally dropped
    assign w_unused_addr = ^{wr_addr, rd_addr};

    line_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_hs),
        .i_waddr (wr_addr[OFFSET_W +: DEPTH_LOG2]),
        .i_wdata (wr_data),
        .i_re    (w_rd_hs),
        .i_raddr (rd_addr[OFFSET_W +: DEPTH_LOG2]),
        .o_rdata (w_arr_q)
    );

    // Write engine next state
    always_comb begin
        w_w_state_nx  = r_w_state;
        w_w_cnt_nx    = r_w_cnt;
        w_wr_ready_nx = r_wr_ready;
        case (r_w_state)
            W_IDLE: begin
                w_wr_ready_nx = 1'b1;
                if (w_wr_hs) begin
                    w_w_state_nx  = W_BUSY;
                    w_wr_ready_nx = 1'b0;
                    w_w_cnt_nx    = CNT_W'(LATENCY - 1);
                end
            end
            W_BUSY: begin
                if (r_w_cnt == '0) begin
                    w_w_state_nx  = W_IDLE;
                    w_wr_ready_nx = 1'b1;
                end else begin
                    w_w_cnt_nx = r_w_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_w_state_nx  = W_IDLE;
                w_wr_ready_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state  <= W_IDLE;
            r_w_cnt    <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            r_w_state  <= w_w_state_nx;
            r_w_cnt    <= w_w_cnt_nx;
            r_wr_ready <= w_wr_ready_nx;
        end
    end

    // Read engine next state; R_WAIT lasts LATENCY-1 cycles
    always_comb begin
        w_r_state_nx   = r_r_state;
        w_r_cnt_nx     = r_r_cnt;
        w_rd_aready_nx = r_rd_aready;
        w_rd_valid_nx  = r_rd_valid;
        w_rd_data_nx   = r_rd_data;
        case (r_r_state)
            R_IDLE: begin
                w_rd_aready_nx = 1'b1;
                if (w_rd_hs) begin
                    w_rd_aready_nx = 1'b0;
                    if (LATENCY == 1) begin
                        w_r_state_nx  = R_RESP;
                        w_rd_valid_nx = 1'b1;
                    end else begin
                        w_r_state_nx = R_WAIT;
                        w_r_cnt_nx   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            R_WAIT: begin
                if (r_r_cnt == '0) begin
                    w_r_state_nx  = R_RESP;
                    w_rd_valid_nx = 1'b1;
                    w_rd_data_nx  = w_arr_q;
                end else begin
                    w_r_cnt_nx = r_r_cnt - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rd_dready) begin
                    w_r_state_nx   = R_IDLE;
                    w_rd_valid_nx  = 1'b0;
                    w_rd_aready_nx = 1'b1;
                end
            end
            default: begin
                w_r_state_nx   = R_IDLE;
                w_rd_aready_nx = 1'b0;
                w_rd_valid_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state   <= R_IDLE;
            r_r_cnt     <= '0;
            r_rd_aready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_r_state   <= w_r_state_nx;
            r_r_cnt     <= w_r_cnt_nx;
            r_rd_aready <= w_rd_aready_nx;
            r_rd_valid  <= w_rd_valid_nx;
            r_rd_data   <= w_rd_data_nx;
        end
    end

    assign wr_ready  = r_wr_ready;
    assign rd_aready = r_rd_aready;
    assign rd_valid  = r_rd_valid;
    // With single-cycle latency the array output register changes on exactly
    // the edge rd_valid rises, so it serves directly as the data register
    assign rd_data   = (LATENCY == 1) ? w_arr_q : r_rd_data;

`ifdef LINE_MEM_OOR_CHECK_EN
    logic r_oor_err;

    // Sticky flag; the access itself still proceeds on the aliased line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oor_err <= 1'b0;
        end else if ((w_wr_hs && addr_oor(wr_addr, DEPTH_LOG2)) ||
                     (w_rd_hs && addr_oor(rd_addr, DEPTH_LOG2))) begin
            r_oor_err <= 1'b1;
        end
    end

    assign oor_err = r_oor_err;
`else
    assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed bench for line_mem_responder with default
// parameters (DEPTH_LOG2=12, LATENCY=4) and LINE_MEM_OOR_CHECK_EN undefined.
module tb_line_mem_responder;

    logic         clk;
    logic         rst;
    logic [26:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [26:0]  rd_addr;
    logic         rd_avalid;
    logic         rd_aready;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_dready;
    logic         oor_err;

    int n_checks;
    int n_errors;

    localparam logic [127:0] ONES    = {128{1'b1}};
    localparam logic [127:0] LINE0_D = 128'hAAAA_5555_AAAA_5555_0123_4567_89AB_CDEF;
    localparam logic [127:0] LINEF_D = 128'h0000_BEEF_0000_CAFE_1111_2222_3333_4444;
    localparam logic [127:0] HOLD_D  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    line_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .rd_avalid (rd_avalid),
        .rd_aready (rd_aready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_dready (rd_dready),
        .oor_err   (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write one line; wr_ready must be low cycles 1..4 and high at cycle 5.
    // With spam set, a conflicting request is held during the busy window.
    task automatic write_line(input logic [26:0] addr, input logic [127:0] data,
                              input bit spam);
        check1("wr_ready_before_hs", wr_ready, 1'b1);
        wr_addr  = addr;
        wr_data  = data;
        wr_valid = 1'b1;
        step();
        if (spam) wr_data = ~data;
        else      wr_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check1($sformatf("wr_ready_busy_c%0d", c), wr_ready, 1'b0);
            if (c == 4) wr_valid = 1'b0;
            step();
        end
        check1("wr_ready_complete_c5", wr_ready, 1'b1);
    endtask

    // Read one line; rd_valid must be low cycles 1..3 and high at cycle 4,
    // optionally held for hold_cycles with rd_dready low before transfer.
    task automatic read_line(input logic [26:0] addr, input logic [127:0] exp,
                             input int hold_cycles);
        check1("rd_aready_before_hs", rd_aready, 1'b1);
        rd_addr   = addr;
        rd_avalid = 1'b1;
        step();
        rd_avalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check1($sformatf("rd_valid_wait_c%0d", c), rd_valid, 1'b0);
            step();
        end
        check1("rd_valid_c4", rd_valid, 1'b1);
        check_line("rd_data_c4", rd_data, exp);
        for (int h = 0; h < hold_cycles; h++) begin
            step();
            check1("rd_valid_hold", rd_valid, 1'b1);
            check_line("rd_data_hold", rd_data, exp);
            check1("rd_aready_hold", rd_aready, 1'b0);
        end
        rd_dready = 1'b1;
        step();
        rd_dready = 1'b0;
        check1("rd_valid_dropped", rd_valid, 1'b0);
        check_line("rd_data_kept", rd_data, exp);
        check1("rd_aready_after_xfer", rd_aready, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        wr_addr   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_addr   = '0;
        rd_avalid = 1'b0;
        rd_dready = 1'b0;

        // Reset values
        repeat (3) step();
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_rd_aready", rd_aready, 1'b0);
        check1("rst_rd_valid", rd_valid, 1'b0);
        check_line("rst_rd_data", rd_data, '0);
        check1("rst_oor_err", oor_err, 1'b0);

        // First cycle after reset release
        rst = 1'b0;
        step();
        check1("post_rst_wr_ready", wr_ready, 1'b1);
        check1("post_rst_rd_aready", rd_aready, 1'b1);

        // Basic write then read of 0xA0
        write_line(27'h00000A0, 128'h1, 1'b0);
        read_line(27'h00000A0, 128'h1, 0);

        // Same-cycle write/read collision on line 1 returns old contents
        write_line(27'h0000010, 128'h5, 1'b0);
        wr_addr   = 27'h0000010;
        wr_data   = ONES;
        wr_valid  = 1'b1;
        rd_addr   = 27'h0000010;
        rd_avalid = 1'b1;
        step();
        wr_valid  = 1'b0;
        rd_avalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check1("coll_rd_valid_wait", rd_valid, 1'b0);
            check1("coll_wr_ready_busy", wr_ready, 1'b0);
            step();
        end
        check1("coll_rd_valid_c4", rd_valid, 1'b1);
        check_line("coll_rd_data_old", rd_data, 128'h5);
        rd_dready = 1'b1;
        step();
        rd_dready = 1'b0;
        check1("coll_wr_ready_c5", wr_ready, 1'b1);
        read_line(27'h0000010, ONES, 0);

        // Writes during busy are ignored
        write_line(27'h0000040, 128'hC0DE, 1'b1);
        read_line(27'h0000040, 128'hC0DE, 0);

        // Hold data under backpressure for 10 cycles
        write_line(27'h0000020, HOLD_D, 1'b0);
        read_line(27'h0000020, HOLD_D, 10);

        // Back-to-back reads of lines 0 and 0xFF
        write_line(27'h0000000, LINE0_D, 1'b0);
        write_line(27'h0000FF0, LINEF_D, 1'b0);
        read_line(27'h0000000, LINE0_D, 0);
        read_line(27'h0000FF0, LINEF_D, 0);

        // Reset two cycles into R_WAIT aborts the read
        write_line(27'h0000030, 128'h77, 1'b0);
        rd_addr   = 27'h0000030;
        rd_avalid = 1'b1;
        step();
        rd_avalid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check1("abort_rd_valid", rd_valid, 1'b0);
        check1("abort_rd_aready", rd_aready, 1'b0);
        check1("abort_wr_ready", wr_ready, 1'b0);
        check_line("abort_rd_data", rd_data, '0);
        step();
        rst = 1'b0;
        step();
        check1("abort_post_rd_aready", rd_aready, 1'b1);
        check1("abort_post_wr_ready", wr_ready, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check1("abort_no_resp", rd_valid, 1'b0);
            step();
        end
        read_line(27'h0000030, 128'h77, 0);
        read_line(27'h00000A0, 128'h1, 0);

        // Out-of-range read aliases to line 0; flag stays low in this build
        read_line(27'h0010000, LINE0_D, 0);
        check1("oor_err_disabled", oor_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
